// File: rtl/des_ctrl_pkg.sv
// Shared types and constants for the DES key-search controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package des_ctrl_pkg;

  localparam int KEY_W              = 56;  // DES key with parity bits stripped
  localparam int BLK_W              = 64;  // DES block
  localparam int CNT_W              = 57;  // keys_tried must be able to hold 2^56
  localparam int TIMEOUT_CYCLES_DEF = 64;  // engine response budget, eng_start to eng_done

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/des_key_range_counter.sv
// Candidate-key register: loads the range start and steps by one, flagging the range end.
// Latency: cur_key updates one cycle after load/inc; last is a compare of registered values.
// Backpressure: none; load and inc are single-cycle commands from the controller FSM.
module des_key_range_counter
  import des_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             inc,
  input  logic [KEY_W-1:0] lo,
  input  logic [KEY_W-1:0] hi,
  output logic [KEY_W-1:0] cur_key,
  output logic             last
);

  logic [KEY_W-1:0] hi_q;

  // Load wins over inc; the FSM only increments while last is low, so the key never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_key <= '0;
      hi_q    <= '0;
    end else if (load) begin
      cur_key <= lo;
      hi_q    <= hi;
    end else if (inc) begin
      cur_key <= cur_key + KEY_W'(1);
    end
  end

  assign last = (cur_key == hi_q);

endmodule

// File: rtl/des_keysearch_controller.sv
// Brute-force known-plaintext DES key search sequencer: one engine launch per candidate key.
// Latency: engine latency + 2 cycles per key (LAUNCH + CHECK); lo > hi reaches DONE in 1 cycle.
// Backpressure: cmd_ready only in IDLE; rsp_valid and status held in DONE until rsp_ack.
module des_keysearch_controller
  import des_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [BLK_W-1:0] cmd_plaintext,
  input  logic [BLK_W-1:0] cmd_target,
  input  logic [KEY_W-1:0] cmd_key_lo,
  input  logic [KEY_W-1:0] cmd_key_hi,
  input  logic             abort,
  output logic             eng_start,
  output logic [BLK_W-1:0] eng_message,
  output logic [KEY_W-1:0] eng_key,
  input  logic             eng_done,
  input  logic [BLK_W-1:0] eng_result,
  output logic             busy,
  output logic             rsp_valid,
  input  logic             rsp_ack,
  output logic             found,
  output logic             exhausted,
  output logic             aborted,
  output logic             timeout_err,
  output logic [KEY_W-1:0] found_key,
  output logic [CNT_W-1:0] keys_tried
);

  // Timer counts cycles elapsed since eng_start; it can reach TIMEOUT_CYCLES when an
  // abort lands on the last WAIT cycle, hence the +1.
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state;
  logic [BLK_W-1:0] pt_q;
  logic [BLK_W-1:0] target_q;
  logic [BLK_W-1:0] result_q;
  logic [TMR_W-1:0] timer;
  logic [KEY_W-1:0] cur_key;
  logic             key_last;
  logic             ctr_load;
  logic             ctr_inc;
  logic             timer_expired;
  logic             match;

  assign timer_expired = (timer >= TMR_W'(TIMEOUT_CYCLES - 1));
  assign match         = (result_q == target_q);
  assign ctr_load      = (state == ST_IDLE) && cmd_valid;
  assign ctr_inc       = (state == ST_CHECK) && !abort && !match && !key_last;

  des_key_range_counter u_key_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ctr_load),
    .inc     (ctr_inc),
    .lo      (cmd_key_lo),
    .hi      (cmd_key_hi),
    .cur_key (cur_key),
    .last    (key_last)
  );

  assign cmd_ready   = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign rsp_valid   = (state == ST_DONE);
  // An abort in LAUNCH suppresses the pulse so the engine is never left running unattended.
  assign eng_start   = (state == ST_LAUNCH) && !abort;
  assign eng_message = pt_q;
  assign eng_key     = cur_key;

  // Main search FSM: job latch, engine handshake, result compare and status reporting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pt_q        <= '0;
      target_q    <= '0;
      result_q    <= '0;
      timer       <= '0;
      keys_tried  <= '0;
      found_key   <= '0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      aborted     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            pt_q        <= cmd_plaintext;
            target_q    <= cmd_target;
            keys_tried  <= '0;
            found_key   <= '0;
            found       <= 1'b0;
            aborted     <= 1'b0;
            timeout_err <= 1'b0;
            if (cmd_key_lo > cmd_key_hi) begin
              exhausted <= 1'b1;
              state     <= ST_DONE;
            end else begin
              exhausted <= 1'b0;
              state     <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= ST_DONE;
          end else begin
            timer <= TMR_W'(1);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (abort && eng_done) begin
            aborted <= 1'b1;
            state   <= ST_DONE;
          end else if (abort) begin
            timer <= timer + TMR_W'(1);
            state <= ST_DRAIN;
          end else if (eng_done) begin
            result_q <= eng_result;
            state    <= ST_CHECK;
          end else if (timer_expired) begin
            timeout_err <= 1'b1;
            state       <= ST_DONE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_CHECK: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= ST_DONE;
          end else begin
            keys_tried <= keys_tried + CNT_W'(1);
            if (match) begin
              found     <= 1'b1;
              found_key <= cur_key;
              state     <= ST_DONE;
            end else if (key_last) begin
              exhausted <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_LAUNCH;
            end
          end
        end
        ST_DRAIN: begin
          if (eng_done || timer_expired) begin
            aborted <= 1'b1;
            state   <= ST_DONE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_DONE: begin
          if (rsp_ack) begin
            found       <= 1'b0;
            exhausted   <= 1'b0;
            aborted     <= 1'b0;
            timeout_err <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_keysearch_controller.sv
// Directed bench for des_keysearch_controller with a behavioural 16-cycle engine model.
// Known-answer mode returns the published DES ciphertext only for the known key/plaintext.
module tb_des_keysearch_controller;
  import des_ctrl_pkg::*;

  localparam int               ENG_LAT = 16;
  localparam logic [KEY_W-1:0] KAT_KEY = 56'h12695BC9B7B7F8;  // 133457799BBCDFF1, parity stripped
  localparam logic [BLK_W-1:0] KAT_PT  = 64'h0123456789ABCDEF;
  localparam logic [BLK_W-1:0] KAT_CT  = 64'h85E813540F0AB405;
  localparam logic [KEY_W-1:0] KEY_MAX = 56'hFF_FFFF_FFFF_FFFF;
  localparam logic [BLK_W-1:0] NO_HIT  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [BLK_W-1:0] cmd_plaintext;
  logic [BLK_W-1:0] cmd_target;
  logic [KEY_W-1:0] cmd_key_lo;
  logic [KEY_W-1:0] cmd_key_hi;
  logic             abort;
  logic             eng_start;
  logic [BLK_W-1:0] eng_message;
  logic [KEY_W-1:0] eng_key;
  logic             eng_done = 1'b0;
  logic [BLK_W-1:0] eng_result = '0;
  logic             busy;
  logic             rsp_valid;
  logic             rsp_ack;
  logic             found;
  logic             exhausted;
  logic             aborted;
  logic             timeout_err;
  logic [KEY_W-1:0] found_key;
  logic [CNT_W-1:0] keys_tried;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  des_keysearch_controller #(.TIMEOUT_CYCLES(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_plaintext (cmd_plaintext),
    .cmd_target    (cmd_target),
    .cmd_key_lo    (cmd_key_lo),
    .cmd_key_hi    (cmd_key_hi),
    .abort         (abort),
    .eng_start     (eng_start),
    .eng_message   (eng_message),
    .eng_key       (eng_key),
    .eng_done      (eng_done),
    .eng_result    (eng_result),
    .busy          (busy),
    .rsp_valid     (rsp_valid),
    .rsp_ack       (rsp_ack),
    .found         (found),
    .exhausted     (exhausted),
    .aborted       (aborted),
    .timeout_err   (timeout_err),
    .found_key     (found_key),
    .keys_tried    (keys_tried)
  );

  // Engine model: 0 = xor model, 1 = never responds, 2 = known-answer DES vector.
  int               eng_mode = 0;
  logic             eng_busy = 1'b0;
  int               eng_cnt  = 0;
  logic [KEY_W-1:0] eng_k    = '0;
  logic [BLK_W-1:0] eng_m    = '0;

  function automatic logic [BLK_W-1:0] eng_func(input logic [BLK_W-1:0] m,
                                                input logic [KEY_W-1:0] k, input int mode);
    if (mode == 2 && k == KAT_KEY && m == KAT_PT) return KAT_CT;
    return m ^ {8'h00, k};
  endfunction

  always @(posedge clk) begin
    eng_done <= 1'b0;
    if (eng_start) begin
      eng_busy <= 1'b1;
      eng_cnt  <= ENG_LAT - 1;
      eng_k    <= eng_key;
      eng_m    <= eng_message;
    end else if (eng_busy && eng_mode != 1) begin
      if (eng_cnt == 1) begin
        eng_done   <= 1'b1;
        eng_result <= eng_func(eng_m, eng_k, eng_mode);
        eng_busy   <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_job(input logic [BLK_W-1:0] pt, input logic [BLK_W-1:0] tgt,
                           input logic [KEY_W-1:0] lo, input logic [KEY_W-1:0] hi);
    @(negedge clk);
    cmd_plaintext = pt;
    cmd_target    = tgt;
    cmd_key_lo    = lo;
    cmd_key_hi    = hi;
    cmd_valid     = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Called on the first negedge after accept (cycle 1); runs until rsp_valid or budget.
  task automatic run_to_done(output int starts, output int cyc, output int gaps_bad, output bit ok);
    int last;
    last = 0; starts = 0; gaps_bad = 0; ok = 1'b0; cyc = 1;
    while (cyc <= 2000) begin
      if (eng_start) begin
        if (starts > 0 && (cyc - last) != ENG_LAT + 2) gaps_bad++;
        starts++;
        last = cyc;
      end
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic ack_rsp();
    rsp_ack = 1'b1;
    @(negedge clk);
    rsp_ack = 1'b0;
  endtask

  typedef struct {
    logic [BLK_W-1:0] pt;
    logic [BLK_W-1:0] tgt;
    logic [KEY_W-1:0] lo;
    logic [KEY_W-1:0] hi;
    int               mode;
    logic             found;
    logic             exh;
    logic [KEY_W-1:0] fkey;
    logic [KEY_W-1:0] ekey;
    logic [CNT_W-1:0] tried;
    int               starts;
    int               cyc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int   st, cy, gb, s, n, d;
    bit   ok;
    string nm;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_plaintext = '0; cmd_target = '0;
    cmd_key_lo = '0; cmd_key_hi = '0; abort = 1'b0; rsp_ack = 1'b0;

    //        pt                      tgt                     lo                 hi                 mode fnd exh fkey           ekey           tried  st cyc
    vecs[0] = '{64'h0,                64'h5,                  56'h0,             56'h9,             0, 1'b1, 1'b0, 56'h5,          56'h5,          57'd6, 6, 109};
    vecs[1] = '{64'h0,                NO_HIT,                 56'h10,            56'h13,            0, 1'b0, 1'b1, 56'h0,          56'h13,         57'd4, 4, 73};
    vecs[2] = '{64'h0,                NO_HIT,                 KEY_MAX,           KEY_MAX,           0, 1'b0, 1'b1, 56'h0,          KEY_MAX,        57'd1, 1, 19};
    vecs[3] = '{64'h0,                64'h0,                  56'h5,             56'h4,             0, 1'b0, 1'b1, 56'h0,          56'h5,          57'd0, 0, 1};
    vecs[4] = '{KAT_PT,               KAT_CT,                 56'h12695BC9B7B7F7, 56'h12695BC9B7B7FA, 2, 1'b1, 1'b0, KAT_KEY,     KAT_KEY,        57'd2, 2, 37};
    vecs[5] = '{64'h1111_0000_0000_0000, 64'h1111_0000_0000_0007, 56'h7,      56'h14,            0, 1'b1, 1'b0, 56'h7,          56'h7,          57'd1, 1, 19};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ctl", {cmd_ready, busy, rsp_valid, eng_start}, 4'b1000);
    chk("reset_flags", {found, exhausted, aborted, timeout_err}, 4'b0000);
    chk("reset_keys_tried", keys_tried, 0);
    chk("reset_eng_key", eng_key, 0);

    for (int i = 0; i < 6; i++) begin
      eng_mode = vecs[i].mode;
      start_job(vecs[i].pt, vecs[i].tgt, vecs[i].lo, vecs[i].hi);
      run_to_done(st, cy, gb, ok);
      nm = $sformatf("v%0d", i);
      chk({nm, "_reached_done"}, ok, 1);
      chk({nm, "_found"}, found, vecs[i].found);
      chk({nm, "_exhausted"}, exhausted, vecs[i].exh);
      chk({nm, "_abort_timeout"}, {aborted, timeout_err}, 2'b00);
      chk({nm, "_found_key"}, found_key, vecs[i].fkey);
      chk({nm, "_keys_tried"}, keys_tried, vecs[i].tried);
      chk({nm, "_eng_key_final"}, eng_key, vecs[i].ekey);
      chk({nm, "_starts"}, st, vecs[i].starts);
      chk({nm, "_done_cycle"}, cy, vecs[i].cyc);
      chk({nm, "_start_spacing"}, gb, 0);
      repeat (3) @(negedge clk);
      chk({nm, "_rsp_held"}, {rsp_valid, found, exhausted}, {1'b1, vecs[i].found, vecs[i].exh});
      ack_rsp();
      chk({nm, "_after_ack"}, {rsp_valid, cmd_ready, busy}, 3'b010);
    end

    // Abort mid-WAIT on key 3: must drain until the engine answers.
    eng_mode = 0;
    start_job(64'h0, NO_HIT, 56'h0, 56'h9);
    s = 0; n = 0;
    while (n < 500) begin
      if (eng_start) s++;
      if (s == 4) break;
      @(negedge clk);
      n++;
    end
    chk("abort_reach_key3", s, 4);
    repeat (5) @(negedge clk);
    chk("abort_eng_key", eng_key, 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("drain_state", {busy, rsp_valid}, 2'b10);
    d = 6;
    while (!rsp_valid && d < 200) begin
      @(negedge clk);
      d++;
    end
    chk("drain_len", d, ENG_LAT + 1);
    chk("abort_flags", {found, exhausted, aborted, timeout_err}, 4'b0010);
    chk("abort_keys_tried", keys_tried, 3);
    ack_rsp();

    // Abort coinciding with eng_done on key 1: result dropped, no increment, no drain.
    start_job(64'h0, NO_HIT, 56'h0, 56'h9);
    s = 0; n = 0;
    while (n < 500) begin
      if (eng_start) s++;
      if (s == 2 && eng_done) break;
      @(negedge clk);
      n++;
    end
    chk("coinc_reached", {s[7:0], eng_done}, {8'd2, 1'b1});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("coinc_done_now", rsp_valid, 1);
    chk("coinc_flags", {found, exhausted, aborted, timeout_err}, 4'b0010);
    chk("coinc_keys_tried", keys_tried, 1);
    ack_rsp();

    // Engine that never answers: timeout exactly 64 cycles after eng_start.
    eng_mode = 1;
    start_job(64'h0, NO_HIT, 56'h0, 56'h3);
    chk("to_start_seen", eng_start, 1);
    d = 0;
    while (!timeout_err && d < 200) begin
      @(negedge clk);
      d++;
    end
    chk("to_cycles", d, 64);
    chk("to_flags", {rsp_valid, found, exhausted, aborted, timeout_err}, 5'b10001);
    chk("to_keys_tried", keys_tried, 0);
    ack_rsp();
    eng_mode = 0;

    // Reset in the middle of WAIT; the late engine answer must be ignored.
    start_job(64'hA5A5_5A5A_0F0F_F0F0, NO_HIT, 56'h20, 56'h30);
    repeat (3) @(negedge clk);
    chk("rst_pre_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_ctl", {cmd_ready, busy, rsp_valid, eng_start}, 4'b1000);
    chk("rst_mid_flags", {found, exhausted, aborted, timeout_err}, 4'b0000);
    chk("rst_mid_msg", eng_message, 0);
    chk("rst_mid_key", {found_key, eng_key}, 0);
    chk("rst_mid_tried", keys_tried, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_late_done_ignored", {cmd_ready, busy, rsp_valid, keys_tried}, {3'b100, 57'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
